carfield_addr_rule_table: RTL and testbench
===========================================

Name: carfield_addr_rule_table

Overview:
Runtime-programmable address-rule table that generalises the static carfield address map to NumRules entries. Software stages rules in a shadow table over a 32-bit register interface, then issues a commit. A multi-cycle validation FSM checks every enabled rule for zero size, address-space overflow and pairwise overlap. Only a clean table is copied atomically into the active table. The active table serves a valid/ready lookup port that returns the matching rule index to an interconnect demux.

Parameters:
NumRules, 16, number of rules; legal range 2..32.
AddrWidth, 64, width of rule base, size and lookup address; legal range 33..64.
IdxWidth, $clog2(NumRules), width of rule index (derived, do not override).
DefaultRules, all-zero rule_t array, reset contents of both shadow and active tables.
DefaultEnable, '0, NumRules-bit reset enable mask.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
cfg_req_i  in  1  register access request
cfg_we_i  in  1  write enable
cfg_addr_i  in  10  byte address, word aligned
cfg_wdata_i  in  32  write data
cfg_rdata_o  out  32  read data, valid in the same cycle as the request
cfg_error_o  out  1  access error, same cycle as the request
lookup_valid_i  in  1  lookup request valid
lookup_ready_o  out  1  lookup request ready
lookup_addr_i  in  AddrWidth  address to decode
result_valid_o  out  1  result valid
result_ready_i  in  1  result accepted
result_hit_o  out  1  address matched an enabled active rule
result_idx_o  out  IdxWidth  matching rule index; 0 when there is no hit
busy_o  out  1  validation in progress
locked_o  out  1  configuration locked

Behaviour:
- Reset: both tables = DefaultRules, enable = DefaultEnable. All outputs 0 except lookup_ready_o = 1. Error status is cleared.
- Register map:
  - rule i at 0x10*i: +0x0 base[31:0], +0x4 base[63:32], +0x8 size[31:0], +0xC size[63:32]. Bits above AddrWidth read 0 and are ignored on write.
  - 0x200: enable mask, bits [NumRules-1:0].
  - 0x204: ctrl. bit0 commit (write-1, self-clearing). bit1 lock (write-1-set; only reset clears it).
  - 0x208: status, read-only. bit0 busy, bit1 err, [3:2] code (0 ok, 1 zero-size, 2 overflow, 3 overlap), [12:8] idx_a, [20:16] idx_b.
- All registers are readable. Reads return shadow contents.
- cfg_error_o = 1, with no state change, on any of:
  - a write while busy_o or locked_o is set;
  - an unmapped address or a rule index >= NumRules;
  - a write to status.
- Validation FSM states: IDLE, CHECK, OVERLAP, APPLY, FAIL.
  - IDLE -> CHECK on an accepted commit write. busy_o rises in the next cycle and status err is cleared.
  - CHECK: one rule per cycle, NumRules cycles, indices 0..N-1. Disabled rules are skipped but still take their cycle.
    - An enabled rule with size == 0 -> FAIL, code 1.
    - An enabled rule with base+size > 2^AddrWidth (sum computed in AddrWidth+1 bits) -> FAIL, code 2.
  - OVERLAP: one pair (i<j) per cycle in lexicographic order, N(N-1)/2 cycles. A pair with both rules enabled and b_i < b_j+s_j && b_j < b_i+s_i -> FAIL, code 3, idx_a=i, idx_b=j.
  - APPLY: copy shadow rules and enable mask to active in one cycle -> IDLE.
  - FAIL: record code and indices, leave active untouched -> IDLE.
  - The first error found aborts the scan. On a clean table busy_o is high for exactly N + N(N-1)/2 + 1 cycles (137 for N=16).
- Lookup (one-stage register slice):
  - Accepted on lookup_valid_i && lookup_ready_o. lookup_ready_o = !result_valid_o || result_ready_i.
  - The result registers next cycle, comparing against the active table as it stood in the accept cycle.
  - Hit when base <= addr < base+size for an enabled rule. The lowest matching index wins.
  - The result is held stable while result_valid_o && !result_ready_i.
  - A lookup accepted in the APPLY cycle uses the old table; the table swap is atomic.
- Reset asserted mid-validation: return to IDLE. The active table reverts to defaults and no partial apply occurs.

Decomposition:
- Package carfield_addr_rule_pkg:
  - rule_t struct {base, size} parametrised by AddrWidth;
  - err_code_e enum;
  - register offset constants;
  - overlap/contains helper functions.
- Sub-module carfield_addr_rule_checker: the CHECK/OVERLAP FSM with its pair counters. It takes the shadow table and enable mask, starts on a start pulse, and returns done, ok, code, idx_a and idx_b.
- The top holds both tables, the register interface and the lookup slice.

Test Plan:
1. Rule0 0x78000000/0x20000, rule1 0x78020000/0x20000, enable 0x3, commit -> busy_o high 137 cycles, status err=0. Lookup 0x7801FFFC -> hit, idx 0. Lookup 0x78020000 -> hit, idx 1. Lookup 0x78040000 -> hit=0, idx 0.
2. Rule2 0x20001000/0x1000000 and rule3 0x20001000/0x1000, enable 0xC, commit -> status code 3, idx_a=2, idx_b=3. Active table unchanged and the previous lookups still hit.
3. Enabled rule5 with size 0 -> code 1, idx_a=5. Rule5 base 0xFFFF_FFFF_FFFF_F000, size 0x2000 -> code 2.
4. Write rule0 while busy_o is set -> cfg_error_o=1 and readback is unchanged. Set lock, then write the enable mask -> cfg_error_o=1 and locked_o=1.
5. Hold result_ready_i=0 for 5 cycles with lookups pending -> lookup_ready_o=0 and the result is stable. A lookup accepted in the APPLY cycle returns the old mapping; the next lookup returns the new one.
6. Assert rst_ni during OVERLAP -> busy_o=0, active table = DefaultRules, status cleared.

Source files
------------

// File: rtl/carfield_addr_rule_pkg.sv
// carfield_addr_rule_pkg
//   Shared types, register offsets and range helpers for the runtime address
//   rule table and its validation checker.
//   rule_t      : {base, size} pair. Fields are sized for the widest legal
//                 address; narrower instances keep the upper bits at zero.
//   err_code_e  : validation result code as reported in the status register.
//   Helpers work on 65-bit end addresses so base+size never wraps.
package carfield_addr_rule_pkg;

  localparam int unsigned MaxAddrWidth = 64;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] base;
    logic [MaxAddrWidth-1:0] size;
  } rule_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_ZERO_SIZE = 2'd1,
    ERR_OVERFLOW  = 2'd2,
    ERR_OVERLAP   = 2'd3
  } err_code_e;

  // Register map (byte offsets within the 1 KiB configuration window)
  localparam logic [9:0] RuleStride   = 10'h010;
  localparam logic [9:0] RegEnableOff = 10'h200;
  localparam logic [9:0] RegCtrlOff   = 10'h204;
  localparam logic [9:0] RegStatusOff = 10'h208;

  localparam int unsigned CtrlCommitBit = 0;
  localparam int unsigned CtrlLockBit   = 1;

  function automatic logic [MaxAddrWidth:0] rule_end(input rule_t r);
    return {1'b0, r.base} + {1'b0, r.size};
  endfunction

  function automatic logic rule_zero_size(input rule_t r);
    return r.size == '0;
  endfunction

  // True when the rule reaches past the top of a 2^aw address space
  function automatic logic rule_overflows(input rule_t r, input int unsigned aw);
    return rule_end(r) > ((MaxAddrWidth+1)'(1) << aw);
  endfunction

  function automatic logic rules_overlap(input rule_t a, input rule_t b);
    return ({1'b0, a.base} < rule_end(b)) && ({1'b0, b.base} < rule_end(a));
  endfunction

  function automatic logic rule_contains(input rule_t r, input logic [MaxAddrWidth-1:0] addr);
    return (addr >= r.base) && ({1'b0, addr} < rule_end(r));
  endfunction

endpackage

// File: rtl/carfield_addr_rule_checker.sv
// carfield_addr_rule_checker
//   Multi-cycle validation of the staged rule table.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : one-cycle pulse, begins a scan (ignored unless idle)
//   rules_i,en_i  : staged table and enable mask (held stable while busy)
//   busy_o        : scan in progress (any state other than IDLE)
//   done_o, ok_o  : one-cycle completion pulse; ok_o=1 means table is clean
//   code_o, idx_a_o, idx_b_o : first error found and the rule(s) involved
//   Sequence: CHECK visits each rule once, OVERLAP visits each pair (i<j) in
//   lexicographic order, then APPLY (clean) or FAIL (error) for one cycle.
module carfield_addr_rule_checker
  import carfield_addr_rule_pkg::*;
#(
  parameter int unsigned NumRules  = 16,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxWidth  = $clog2(NumRules)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  rule_t        [NumRules-1:0]  rules_i,
  input  logic         [NumRules-1:0]  en_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         ok_o,
  output err_code_e                    code_o,
  output logic         [IdxWidth-1:0]  idx_a_o,
  output logic         [IdxWidth-1:0]  idx_b_o
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    OVERLAP,
    APPLY,
    FAIL
  } state_e;

  localparam logic [IdxWidth-1:0] LastIdx    = IdxWidth'(NumRules - 1);
  localparam logic [IdxWidth-1:0] PenultIdx  = IdxWidth'(NumRules - 2);

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] i_q, i_d, j_q, j_d;
  err_code_e           code_q, code_d;
  logic [IdxWidth-1:0] idx_a_q, idx_a_d, idx_b_q, idx_b_d;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    code_d  = code_q;
    idx_a_d = idx_a_q;
    idx_b_d = idx_b_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CHECK;
          i_d     = '0;
          j_d     = '0;
          code_d  = ERR_NONE;
          idx_a_d = '0;
          idx_b_d = '0;
        end
      end
      CHECK: begin
        if (en_i[i_q] && rule_zero_size(rules_i[i_q])) begin
          state_d = FAIL;
          code_d  = ERR_ZERO_SIZE;
          idx_a_d = i_q;
          idx_b_d = '0;
        end else if (en_i[i_q] && rule_overflows(rules_i[i_q], AddrWidth)) begin
          state_d = FAIL;
          code_d  = ERR_OVERFLOW;
          idx_a_d = i_q;
          idx_b_d = '0;
        end else if (i_q == LastIdx) begin
          state_d = OVERLAP;
          i_d     = '0;
          j_d     = IdxWidth'(1);
        end else begin
          i_d = i_q + IdxWidth'(1);
        end
      end
      OVERLAP: begin
        if (en_i[i_q] && en_i[j_q] && rules_overlap(rules_i[i_q], rules_i[j_q])) begin
          state_d = FAIL;
          code_d  = ERR_OVERLAP;
          idx_a_d = i_q;
          idx_b_d = j_q;
        end else if (j_q == LastIdx) begin
          if (i_q == PenultIdx) begin
            state_d = APPLY;
          end else begin
            // Next row of the pair triangle starts just right of the diagonal
            i_d = i_q + IdxWidth'(1);
            j_d = IdxWidth'(32'(i_q) + 32'd2);
          end
        end else begin
          j_d = j_q + IdxWidth'(1);
        end
      end
      APPLY:   state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      code_q  <= ERR_NONE;
      idx_a_q <= '0;
      idx_b_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      code_q  <= code_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
    end
  end

  assign busy_o  = state_q != IDLE;
  assign done_o  = (state_q == APPLY) || (state_q == FAIL);
  assign ok_o    = state_q == APPLY;
  assign code_o  = code_q;
  assign idx_a_o = idx_a_q;
  assign idx_b_o = idx_b_q;

endmodule

// File: rtl/carfield_addr_rule_table.sv
// carfield_addr_rule_table
//   Runtime-programmable address rule table with shadow/active copies.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   cfg_*                : 32-bit register port; rdata/error are combinational
//                          in the request cycle, writes take effect at the edge
//   lookup_valid/ready/addr : lookup request handshake
//   result_valid/ready/hit/idx : registered lookup result (one-stage slice)
//   busy_o               : validation in progress
//   locked_o             : configuration locked until reset
module carfield_addr_rule_table
  import carfield_addr_rule_pkg::*;
#(
  parameter int unsigned                 NumRules      = 16,
  parameter int unsigned                 AddrWidth     = 64,
  parameter int unsigned                 IdxWidth      = $clog2(NumRules),
  parameter rule_t       [NumRules-1:0]  DefaultRules  = '0,
  parameter logic        [NumRules-1:0]  DefaultEnable = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_req_i,
  input  logic                  cfg_we_i,
  input  logic [9:0]            cfg_addr_i,
  input  logic [31:0]           cfg_wdata_i,
  output logic [31:0]           cfg_rdata_o,
  output logic                  cfg_error_o,
  input  logic                  lookup_valid_i,
  output logic                  lookup_ready_o,
  input  logic [AddrWidth-1:0]  lookup_addr_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  result_hit_o,
  output logic [IdxWidth-1:0]   result_idx_o,
  output logic                  busy_o,
  output logic                  locked_o
);

  // Bits above AddrWidth are forced to zero on every write into a table
  localparam logic [63:0] AddrMask =
    (AddrWidth >= 64) ? {64{1'b1}} : ((64'd1 << AddrWidth) - 64'd1);

  rule_t [NumRules-1:0] shadow_q, active_q;
  logic  [NumRules-1:0] en_shadow_q, en_active_q;
  logic                 lock_q;
  logic                 err_q;
  err_code_e            code_q;
  logic [IdxWidth-1:0]  idx_a_q, idx_b_q;

  logic                 chk_busy, chk_done, chk_ok;
  err_code_e            chk_code;
  logic [IdxWidth-1:0]  chk_idx_a, chk_idx_b;

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  logic [4:0]          rule_idx;
  logic [1:0]          rule_word;
  logic [IdxWidth-1:0] rule_sel;
  logic                aligned, is_rule, is_en, is_ctrl, is_status, addr_ok;
  logic                wr_ok, commit;

  assign aligned   = cfg_addr_i[1:0] == 2'b00;
  assign rule_idx  = cfg_addr_i[8:4];
  assign rule_word = cfg_addr_i[3:2];
  assign rule_sel  = rule_idx[IdxWidth-1:0];
  assign is_rule   = aligned && !cfg_addr_i[9] && (32'(rule_idx) < NumRules);
  assign is_en     = aligned && (cfg_addr_i[9:2] == RegEnableOff[9:2]);
  assign is_ctrl   = aligned && (cfg_addr_i[9:2] == RegCtrlOff[9:2]);
  assign is_status = aligned && (cfg_addr_i[9:2] == RegStatusOff[9:2]);
  assign addr_ok   = is_rule || is_en || is_ctrl || is_status;

  assign cfg_error_o = cfg_req_i &&
                       (!addr_ok || (cfg_we_i && (chk_busy || lock_q || is_status)));
  assign wr_ok  = cfg_req_i && cfg_we_i && !cfg_error_o;
  assign commit = wr_ok && is_ctrl && cfg_wdata_i[CtrlCommitBit];

  always_comb begin
    rule_t sel;
    cfg_rdata_o = '0;
    sel         = shadow_q[rule_sel];
    if (cfg_req_i && addr_ok) begin
      if (is_rule) begin
        unique case (rule_word)
          2'd0:    cfg_rdata_o = sel.base[31:0];
          2'd1:    cfg_rdata_o = sel.base[63:32];
          2'd2:    cfg_rdata_o = sel.size[31:0];
          default: cfg_rdata_o = sel.size[63:32];
        endcase
      end else if (is_en) begin
        cfg_rdata_o[NumRules-1:0] = en_shadow_q;
      end else if (is_ctrl) begin
        cfg_rdata_o[CtrlLockBit] = lock_q;
      end else begin
        cfg_rdata_o[0]                = chk_busy;
        cfg_rdata_o[1]                = err_q;
        cfg_rdata_o[3:2]              = code_q;
        cfg_rdata_o[8 +: IdxWidth]    = idx_a_q;
        cfg_rdata_o[16 +: IdxWidth]   = idx_b_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tables, control and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NumRules; k++) begin
        shadow_q[k].base <= DefaultRules[k].base & AddrMask;
        shadow_q[k].size <= DefaultRules[k].size & AddrMask;
        active_q[k].base <= DefaultRules[k].base & AddrMask;
        active_q[k].size <= DefaultRules[k].size & AddrMask;
      end
      en_shadow_q <= DefaultEnable;
      en_active_q <= DefaultEnable;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      idx_a_q     <= '0;
      idx_b_q     <= '0;
    end else begin
      if (wr_ok && is_rule) begin
        unique case (rule_word)
          2'd0:    shadow_q[rule_sel].base[31:0]  <= cfg_wdata_i & AddrMask[31:0];
          2'd1:    shadow_q[rule_sel].base[63:32] <= cfg_wdata_i & AddrMask[63:32];
          2'd2:    shadow_q[rule_sel].size[31:0]  <= cfg_wdata_i & AddrMask[31:0];
          default: shadow_q[rule_sel].size[63:32] <= cfg_wdata_i & AddrMask[63:32];
        endcase
      end
      if (wr_ok && is_en) begin
        en_shadow_q <= cfg_wdata_i[NumRules-1:0];
      end
      if (wr_ok && is_ctrl && cfg_wdata_i[CtrlLockBit]) begin
        lock_q <= 1'b1;
      end
      if (commit) begin
        err_q   <= 1'b0;
        code_q  <= ERR_NONE;
        idx_a_q <= '0;
        idx_b_q <= '0;
      end
      // Whole-table copy in a single edge keeps the swap atomic for lookups
      if (chk_done) begin
        if (chk_ok) begin
          active_q    <= shadow_q;
          en_active_q <= en_shadow_q;
        end else begin
          err_q   <= 1'b1;
          code_q  <= chk_code;
          idx_a_q <= chk_idx_a;
          idx_b_q <= chk_idx_b;
        end
      end
    end
  end

  carfield_addr_rule_checker #(
    .NumRules  (NumRules),
    .AddrWidth (AddrWidth),
    .IdxWidth  (IdxWidth)
  ) u_checker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (commit),
    .rules_i (shadow_q),
    .en_i    (en_shadow_q),
    .busy_o  (chk_busy),
    .done_o  (chk_done),
    .ok_o    (chk_ok),
    .code_o  (chk_code),
    .idx_a_o (chk_idx_a),
    .idx_b_o (chk_idx_b)
  );

  assign busy_o   = chk_busy;
  assign locked_o = lock_q;

  // ---------------------------------------------------------------------------
  // Lookup slice
  // ---------------------------------------------------------------------------
  logic                match_hit;
  logic [IdxWidth-1:0] match_idx;
  logic                res_valid_q, res_hit_q;
  logic [IdxWidth-1:0] res_idx_q;

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int unsigned k = 0; k < NumRules; k++) begin
      if (!match_hit && en_active_q[k] && rule_contains(active_q[k], 64'(lookup_addr_i))) begin
        match_hit = 1'b1;
        match_idx = IdxWidth'(k);
      end
    end
  end

  assign lookup_ready_o = !res_valid_q || result_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
    end else if (lookup_valid_i && lookup_ready_o) begin
      res_valid_q <= 1'b1;
      res_hit_q   <= match_hit;
      res_idx_q   <= match_idx;
    end else if (result_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

  assign result_valid_o = res_valid_q;
  assign result_hit_o   = res_hit_q;
  assign result_idx_o   = res_idx_q;

endmodule

// File: tb/tb_carfield_addr_rule_table.sv
// tb_carfield_addr_rule_table
//   Directed, self-checking bench for carfield_addr_rule_table (N=16, 64-bit).
module tb_carfield_addr_rule_table;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 4;

  localparam logic [9:0] A_EN     = 10'h200;
  localparam logic [9:0] A_CTRL   = 10'h204;
  localparam logic [9:0] A_STATUS = 10'h208;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_req = 1'b0, cfg_we = 1'b0;
  logic [9:0]    cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic [31:0]   cfg_rdata;
  logic          cfg_error;
  logic          lk_valid = 1'b0;
  logic          lk_ready;
  logic [AW-1:0] lk_addr = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic          res_hit;
  logic [IW-1:0] res_idx;
  logic          busy, locked;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  carfield_addr_rule_table #(
    .NumRules  (N),
    .AddrWidth (AW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_req_i      (cfg_req),
    .cfg_we_i       (cfg_we),
    .cfg_addr_i     (cfg_addr),
    .cfg_wdata_i    (cfg_wdata),
    .cfg_rdata_o    (cfg_rdata),
    .cfg_error_o    (cfg_error),
    .lookup_valid_i (lk_valid),
    .lookup_ready_o (lk_ready),
    .lookup_addr_i  (lk_addr),
    .result_valid_o (res_valid),
    .result_ready_i (res_ready),
    .result_hit_o   (res_hit),
    .result_idx_o   (res_idx),
    .busy_o         (busy),
    .locked_o       (locked)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic b, input logic e, input logic [1:0] c,
                                     input logic [4:0] ia, input logic [4:0] ib);
    logic [31:0] w;
    w = '0;
    w[0] = b; w[1] = e; w[3:2] = c; w[12:8] = ia; w[20:16] = ib;
    return w;
  endfunction

  task automatic cfg_access(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
    @(negedge clk);
    cfg_req = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wdata;
    #1;
    rdata = cfg_rdata;
    err   = cfg_error;
    @(posedge clk);
    #1;
    cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic wr(input string name, input logic [9:0] addr, input logic [31:0] data,
                    input logic exp_err);
    logic [31:0] rd_d;
    logic        e;
    cfg_access(1'b1, addr, data, rd_d, e);
    check({name, "_err"}, e, exp_err);
  endtask

  task automatic rd(input string name, input logic [9:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    cfg_access(1'b0, addr, 32'h0, d, e);
    check(name, d, exp);
  endtask

  task automatic wr_rule(input int unsigned idx, input logic [63:0] base, input logic [63:0] size);
    logic [9:0] a;
    a = 10'(idx * 16);
    wr("rule_b0", a,         base[31:0],  1'b0);
    wr("rule_b1", a + 10'h4, base[63:32], 1'b0);
    wr("rule_s0", a + 10'h8, size[31:0],  1'b0);
    wr("rule_s1", a + 10'hC, size[63:32], 1'b0);
  endtask

  // Counts busy cycles, starting right after the commit edge
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("busy_bound", busy, 1'b0);
  endtask

  task automatic lookup(input logic [63:0] a, output logic v, output logic h, output logic [IW-1:0] i);
    @(negedge clk);
    lk_valid = 1'b1; lk_addr = a; res_ready = 1'b1;
    @(posedge clk);
    #1;
    lk_valid = 1'b0;
    v = res_valid; h = res_hit; i = res_idx;
  endtask

  typedef struct {
    logic [63:0]   addr;
    logic          hit;
    logic [IW-1:0] idx;
  } lvec_t;

  lvec_t vt[7];

  initial begin
    int            n;
    logic          v, h;
    logic [IW-1:0] ix;

    vt[0] = '{64'h7801_FFFC, 1'b1, 4'd0};
    vt[1] = '{64'h7802_0000, 1'b1, 4'd1};
    vt[2] = '{64'h7804_0000, 1'b0, 4'd0};
    vt[3] = '{64'h7800_0000, 1'b1, 4'd0};
    vt[4] = '{64'h77FF_FFFF, 1'b0, 4'd0};
    vt[5] = '{64'h7803_FFFF, 1'b1, 4'd1};
    vt[6] = '{64'h0000_0000, 1'b0, 4'd0};

    // ---------------- reset state ----------------
    #2;
    check("rst_lk_ready", lk_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_cfg_error", cfg_error, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd("rst_status", A_STATUS, 32'h0);
    rd("rst_rule0", 10'h000, 32'h0);
    rd("rst_en", A_EN, 32'h0);
    lookup(64'h7800_0000, v, h, ix);
    check("rst_lk_hit", h, 1'b0);

    // Access errors: unmapped, rule index >= N, status write, misaligned
    wr("err_unmapped", 10'h20C, 32'h1, 1'b1);
    wr("err_idx16", 10'h100, 32'h1, 1'b1);
    wr("err_status", A_STATUS, 32'h1, 1'b1);
    wr("err_misalign", 10'h001, 32'h1, 1'b1);
    rd("err_idx16_noeffect", 10'h000, 32'h0);

    // ---------------- test 1: clean commit ----------------
    wr_rule(0, 64'h7800_0000, 64'h2_0000);
    wr_rule(1, 64'h7802_0000, 64'h2_0000);
    wr("t1_en", A_EN, 32'h3, 1'b0);
    rd("t1_rd_size1", 10'h018, 32'h2_0000);
    rd("t1_rd_en", A_EN, 32'h3);
    wr("t1_commit", A_CTRL, 32'h1, 1'b0);
    wait_idle(n);
    check("t1_busy_cycles", 64'(n), 64'd137);
    rd("t1_status", A_STATUS, st(1'b0, 1'b0, 2'd0, 5'd0, 5'd0));
    rd("t1_ctrl", A_CTRL, 32'h0);
    for (int k = 0; k < 7; k++) begin
      lookup(vt[k].addr, v, h, ix);
      check($sformatf("t1_lk%0d_valid", k), v, 1'b1);
      check($sformatf("t1_lk%0d_hit", k), h, vt[k].hit);
      check($sformatf("t1_lk%0d_idx", k), ix, vt[k].idx);
    end

    // ---------------- test 2: overlap ----------------
    wr_rule(2, 64'h2000_1000, 64'h100_0000);
    wr_rule(3, 64'h2000_1000, 64'h1000);
    wr("t2_en", A_EN, 32'hC, 1'b0);
    wr("t2_commit", A_CTRL, 32'h1, 1'b0);
    wait_idle(n);
    rd("t2_status", A_STATUS, st(1'b0, 1'b1, 2'd3, 5'd2, 5'd3));
    lookup(64'h7801_FFFC, v, h, ix);
    check("t2_old_hit", h, 1'b1);
    check("t2_old_idx", ix, 4'd0);
    lookup(64'h2000_1000, v, h, ix);
    check("t2_new_miss", h, 1'b0);

    // ---------------- test 3: zero size, overflow ----------------
    wr("t3_en", A_EN, 32'h20, 1'b0);
    wr("t3_commit0", A_CTRL, 32'h1, 1'b0);
    wait_idle(n);
    rd("t3_status_zero", A_STATUS, st(1'b0, 1'b1, 2'd1, 5'd5, 5'd0));
    wr_rule(5, 64'hFFFF_FFFF_FFFF_F000, 64'h2000);
    wr("t3_commit1", A_CTRL, 32'h1, 1'b0);
    wait_idle(n);
    rd("t3_status_ovf", A_STATUS, st(1'b0, 1'b1, 2'd2, 5'd5, 5'd0));

    // ---------------- test 4a: write while busy ----------------
    wr("t4_en", A_EN, 32'h3, 1'b0);
    wr("t4_commit", A_CTRL, 32'h1, 1'b0);
    check("t4_busy", busy, 1'b1);
    wr("t4_busy_write", 10'h000, 32'h1234_5678, 1'b1);
    rd("t4_readback", 10'h000, 32'h7800_0000);
    rd("t4_status_busy", A_STATUS, st(1'b1, 1'b0, 2'd0, 5'd0, 5'd0));
    wait_idle(n);
    rd("t4_status", A_STATUS, 32'h0);

    // ---------------- test 5a: result backpressure ----------------
    @(negedge clk);
    res_ready = 1'b0; lk_valid = 1'b1; lk_addr = 64'h7802_0000;
    @(posedge clk);
    #1;
    lk_addr = 64'h7801_FFFC;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t5_bp%0d_lk_ready", c), lk_ready, 1'b0);
      check($sformatf("t5_bp%0d_valid", c), res_valid, 1'b1);
      check($sformatf("t5_bp%0d_hit", c), res_hit, 1'b1);
      check($sformatf("t5_bp%0d_idx", c), res_idx, 4'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    check("t5_release_lk_ready", lk_ready, 1'b1);
    @(posedge clk);
    #1;
    lk_valid = 1'b0;
    check("t5_second_valid", res_valid, 1'b1);
    check("t5_second_idx", res_idx, 4'd0);

    // ---------------- test 5b: lookup in the APPLY cycle ----------------
    wr_rule(1, 64'h9000_0000, 64'h1000);
    wr("t5_commit", A_CTRL, 32'h1, 1'b0);
    repeat (136) @(posedge clk);
    #1;
    check("t5_apply_busy", busy, 1'b1);
    lk_valid = 1'b1; lk_addr = 64'h9000_0000; res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_apply_done", busy, 1'b0);
    check("t5_apply_valid", res_valid, 1'b1);
    check("t5_apply_old_hit", res_hit, 1'b0);
    check("t5_apply_old_idx", res_idx, 4'd0);
    @(posedge clk);
    #1;
    lk_valid = 1'b0;
    check("t5_next_hit", res_hit, 1'b1);
    check("t5_next_idx", res_idx, 4'd1);
    lookup(64'h7802_0000, v, h, ix);
    check("t5_moved_miss", h, 1'b0);

    // ---------------- test 6: reset during OVERLAP ----------------
    wr("t6_commit", A_CTRL, 32'h1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("t6_busy_before", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_lk_ready", lk_ready, 1'b1);
    check("t6_rst_res_valid", res_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd("t6_status", A_STATUS, 32'h0);
    rd("t6_rule0", 10'h000, 32'h0);
    rd("t6_en", A_EN, 32'h0);
    lookup(64'h7801_FFFC, v, h, ix);
    check("t6_lk_hit", h, 1'b0);
    check("t6_lk_idx", ix, 4'd0);
    check("t6_busy_after", busy, 1'b0);

    // ---------------- test 4b: lock ----------------
    wr("t4_lock", A_CTRL, 32'h2, 1'b0);
    check("t4_locked", locked, 1'b1);
    rd("t4_ctrl_lock", A_CTRL, 32'h2);
    wr("t4_locked_en", A_EN, 32'hFFFF, 1'b1);
    rd("t4_locked_en_rd", A_EN, 32'h0);
    wr("t4_locked_commit", A_CTRL, 32'h1, 1'b1);
    check("t4_locked_nobusy", busy, 1'b0);
    check("t4_still_locked", locked, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
